mini16_s2m_arbiter: RTL and testbench

//  Round-robin write arbiter that shares the single write port of the slave-to-master

---
 rtl/mini16_s2m_arbiter_pkg.sv | 18 +
 rtl/mini16_s2m_arbiter_rr_pick.sv | 33 +++
 rtl/mini16_s2m_arbiter.sv | 78 +++++++
 tb/tb_mini16_s2m_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mini16_s2m_arbiter_pkg.sv
// Shared constants and helpers for the shared_s2m write arbiter.
package mini16_s2m_arbiter_pkg;

  localparam int CORES_DEF       = 4;
  localparam int DEPTH_LOCAL_DEF = 4;
  localparam int WIDTH_D_DEF     = 32;

  // Index width for n items; never returns less than 1 so a 1-bit index always exists.
  function automatic int mini16_log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mini16_s2m_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of vec starting at ptr, wrapping at N.
module mini16_rr_pick
  import mini16_s2m_arbiter_pkg::*;
#(
  parameter int N      = 4,
  parameter int N_BITS = 2
) (
  input  logic [N-1:0]      vec,
  input  logic [N_BITS-1:0] ptr,
  output logic [N-1:0]      onehot,
  output logic [N_BITS-1:0] idx,
  output logic              valid
);

  // Scan offsets from the farthest back to ptr so the closest eligible index wins last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int c;
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (vec[c]) begin
        onehot    = '0;
        onehot[c] = 1'b1;
        idx       = N_BITS'(c);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mini16_s2m_arbiter.sv
// Round-robin arbiter sharing the single shared_s2m write port among the PEs.
// Each PE's local address is tagged with its core index, giving it a private window.
module mini16_s2m_arbiter
  import mini16_s2m_arbiter_pkg::*;
#(
  parameter int CORES       = CORES_DEF,
  parameter int CORE_BITS   = mini16_log2(CORES),
  parameter int DEPTH_LOCAL = DEPTH_LOCAL_DEF,
  parameter int WIDTH_D     = WIDTH_D_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CORES-1:0]                 req,
  input  logic [CORES*DEPTH_LOCAL-1:0]     req_addr,
  input  logic [CORES*WIDTH_D-1:0]         req_data,
  output logic [CORES-1:0]                 ack,
  input  logic [CORES-1:0]                 core_en,
  input  logic                             freeze,
  output logic                             ram_we,
  output logic [CORE_BITS+DEPTH_LOCAL-1:0] ram_addr,
  output logic [WIDTH_D-1:0]               ram_data,
  output logic                             busy
);

  logic [CORE_BITS-1:0] rr_ptr;
  logic [CORE_BITS-1:0] ptr_next;
  logic [CORES-1:0]     eligible;
  logic [CORES-1:0]     onehot;
  logic [CORE_BITS-1:0] g;
  logic                 grant;

  // Requests from disabled cores, and all requests under freeze or reset, are invisible.
  always_comb begin
    eligible = req & core_en;
    if (reset || freeze) eligible = '0;
  end

  mini16_rr_pick #(
    .N      (CORES),
    .N_BITS (CORE_BITS)
  ) u_pick (
    .vec    (eligible),
    .ptr    (rr_ptr),
    .onehot (onehot),
    .idx    (g),
    .valid  (grant)
  );

  assign ack = onehot;

  // Pointer moves just past the winner; explicit wrap keeps it below CORES for any count.
  always_comb begin
    if (int'(g) == CORES - 1) ptr_next = '0;
    else                      ptr_next = g + CORE_BITS'(1);
  end

  // Register the winning write; on idle cycles only the write enable drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      busy <= |(req & core_en);
      if (grant) begin
        ram_we   <= 1'b1;
        ram_addr <= {g, req_addr[g*DEPTH_LOCAL +: DEPTH_LOCAL]};
        ram_data <= req_data[g*WIDTH_D +: WIDTH_D];
        rr_ptr   <= ptr_next;
      end else begin
        ram_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mini16_s2m_arbiter.sv
// Bench for mini16_s2m_arbiter: directed scenarios then randomized PE traffic,
// all checked against a behavioural round-robin model.
module tb_mini16_s2m_arbiter;

  localparam int NC = 4;
  localparam int DL = 4;
  localparam int WD = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     req;
  logic [NC*DL-1:0]  req_addr;
  logic [NC*WD-1:0]  req_data;
  logic [NC-1:0]     ack;
  logic [NC-1:0]     core_en;
  logic              freeze;
  logic              ram_we;
  logic [2+DL-1:0]   ram_addr;
  logic [WD-1:0]     ram_data;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  // model state
  int          m_ptr;
  logic        m_we;
  logic [5:0]  m_addr;
  logic [31:0] m_data;
  logic        m_busy;
  logic [3:0]  m_ack;
  logic [3:0]  obs_ack;
  logic [3:0]  pend;

  always #5 clk = ~clk;

  mini16_s2m_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .core_en  (core_en),
    .freeze   (freeze),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner = first core, counting up from the pointer modulo the core count, that
  // requests, is enabled, and is not blocked by freeze/reset. -1 when none.
  function automatic int model_winner();
    if (reset || freeze) return -1;
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (m_ptr + k) % NC;
      if (req[c] && core_en[c]) return c;
    end
    return -1;
  endfunction

  // One clock: inputs already set at the falling edge.
  task automatic cyc();
    int w;
    #1;
    w = model_winner();
    m_ack = (w >= 0) ? 4'(1 << w) : 4'b0000;
    obs_ack = ack;
    chk("ack", {60'b0, ack}, {60'b0, m_ack});
    @(posedge clk);
    if (reset) begin
      m_we = 0; m_addr = 0; m_data = 0; m_busy = 0; m_ptr = 0;
    end else begin
      m_busy = |(req & core_en);
      if (w >= 0) begin
        m_we   = 1;
        m_addr = {w[1:0], req_addr[w*DL +: DL]};
        m_data = req_data[w*WD +: WD];
        m_ptr  = (w + 1) % NC;
      end else begin
        m_we = 0;
      end
    end
    #1;
    chk("ram_we",   {63'b0, ram_we},   {63'b0, m_we});
    chk("ram_addr", {58'b0, ram_addr}, {58'b0, m_addr});
    chk("ram_data", {32'b0, ram_data}, {32'b0, m_data});
    chk("busy",     {63'b0, busy},     {63'b0, m_busy});
    @(negedge clk);
  endtask

  task automatic set_all_random_payload();
    for (int i = 0; i < NC; i++) begin
      req_addr[i*DL +: DL] = 4'($urandom_range(0, 15));
      req_data[i*WD +: WD] = $urandom;
    end
  endtask

  initial begin
    logic [3:0] order_a [6];
    reset = 1; freeze = 0; core_en = 4'b1111; req = 4'b1111;
    req_addr = '0; req_data = '0;
    m_ptr = 0; m_we = 0; m_addr = 0; m_data = 0; m_busy = 0; pend = 0;
    set_all_random_payload();
    @(negedge clk);

    // 1: reset held with all requesting
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("rst_ack", {60'b0, obs_ack}, 64'h0);
      chk("rst_we",  {63'b0, ram_we},  64'h0);
      chk("rst_busy",{63'b0, busy},    64'h0);
    end
    reset = 0; req = 0;
    cyc();

    // 2: single requester PE2, addr 5, data DEADBEEF
    req = 4'b0100;
    req_addr[2*DL +: DL] = 4'd5;
    req_data[2*WD +: WD] = 32'hDEADBEEF;
    cyc();
    chk("s2_ack",  {60'b0, obs_ack},  64'h4);
    chk("s2_addr", {58'b0, ram_addr}, 64'h25);
    chk("s2_data", {32'b0, ram_data}, 64'hDEADBEEF);
    chk("s2_we",   {63'b0, ram_we},   64'h1);
    req = 0;
    cyc();
    chk("s2_idle_we", {63'b0, ram_we}, 64'h0);

    // bring pointer to 0 via PE3
    req = 4'b1000;
    cyc();
    chk("s3_pre_ack", {60'b0, obs_ack}, 64'h8);

    // 3: fairness with all four requesting
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      set_all_random_payload();
      cyc();
      chk("s3_ack",  {60'b0, obs_ack},       64'(1 << (i % 4)));
      chk("s3_core", {62'b0, ram_addr[5:4]}, 64'(i % 4));
      chk("s3_we",   {63'b0, ram_we},        64'h1);
    end

    // 4: mask PE2
    core_en = 4'b1011;
    order_a = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("s4_mask_ack", {60'b0, obs_ack}, {60'b0, order_a[i]});
    end
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("s4_frz_ack",  {60'b0, obs_ack}, 64'h0);
      chk("s4_frz_we",   {63'b0, ram_we},  64'h0);
      chk("s4_frz_busy", {63'b0, busy},    64'h1);
    end
    freeze = 0;
    cyc();
    chk("s4_after_frz", {60'b0, obs_ack}, 64'h1);

    // 5: wrap; pointer now 1, PE2 alone moves it to 3
    core_en = 4'b1111;
    req = 4'b0100;
    cyc();
    chk("s5_pre", {60'b0, obs_ack}, 64'h4);
    req = 4'b1001;
    cyc();
    chk("s5_first", {60'b0, obs_ack}, 64'h8);
    req = 4'b0001;
    cyc();
    chk("s5_second", {60'b0, obs_ack}, 64'h1);
    req = 4'b1111;
    cyc();
    chk("s5_ptr1", {60'b0, obs_ack}, 64'h2);

    // 6: reset mid-burst
    cyc();
    reset = 1;
    cyc();
    chk("s6_rst_ack", {60'b0, obs_ack}, 64'h0);
    chk("s6_rst_we",  {63'b0, ram_we},  64'h0);
    reset = 0;
    cyc();
    chk("s6_restart", {60'b0, obs_ack}, 64'h1);

    // randomized traffic: PEs hold until acked, then may issue a new request
    req = 0; pend = 0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NC; i++) begin
        if (pend[i] && m_ack[i]) pend[i] = 0;
        if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
          pend[i] = 1;
          req_addr[i*DL +: DL] = 4'($urandom_range(0, 15));
          req_data[i*WD +: WD] = $urandom;
        end
      end
      req = pend;
      if ($urandom_range(0, 19) == 0) core_en = 4'($urandom_range(0, 15));
      freeze = ($urandom_range(0, 9) == 0);
      reset  = ($urandom_range(0, 49) == 0);
      cyc();
      if (reset) m_ack = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
